sam_arbiter: RTL

- Round-robin scheduler that shares one SAM shift-and-add multiplier among N requesters.
- Accepts operand pairs over a per-requester Req/Gnt handshake, drives the SAM Start/A/B inputs, and captures R on Done.
- Returns each product to its owner with a one-cycle RspValid pulse.
- Sits between client datapaths and a single SAM instance. Shares Clock/Reset with that instance; does not drive the SAM reset.

---
 rtl/sam_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sam_arbiter.sv
// sam_arbiter: round-robin front end that shares one SAM shift-and-add
// multiplier among N requesters.
//
// A requester raises Req with its operands; the arbiter picks a winner in
// IDLE, pulses Gnt and MulStart together in ISSUE, waits in WAIT for a rising
// edge on MulDone, then pulses RspValid to the owner in RESP with the product
// on RspR.
//
// Ports:
//   Clock, Reset        system clock (rising edge), async active-high reset
//   Req[N]              per-requester request, held until Gnt
//   ReqA/ReqB[N*W]      packed operands, slice i = [i*W +: W]
//   Gnt[N]              one-hot pulse, operands accepted
//   RspValid[N]         one-hot pulse, product ready for owner
//   RspR[2W]            product, stable until the next response
//   RspErr              watchdog timeout flag, qualified by RspValid
//   Busy                high whenever the FSM is not in IDLE
//   MulStart/MulA/MulB  to the SAM instance
//   MulR/MulDone        from the SAM instance
//
// Optional feature: define SAM_TIMEOUT_EN to build a WAIT watchdog that
// forces an error response after TIMEOUT_CYCLES cycles without completion.
// Without it, WAIT lasts until MulDone rises and RspErr is tied low.

module sam_arbiter #(
  parameter int N              = 4,
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [N-1:0]     Req,
  input  logic [N*W-1:0]   ReqA,
  input  logic [N*W-1:0]   ReqB,
  output logic [N-1:0]     Gnt,
  output logic [N-1:0]     RspValid,
  output logic [2*W-1:0]   RspR,
  output logic             RspErr,
  output logic             Busy,
  output logic             MulStart,
  output logic [W-1:0]     MulA,
  output logic [W-1:0]     MulB,
  input  logic [2*W-1:0]   MulR,
  input  logic             MulDone
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [W-1:0]    mul_a_q, mul_a_d;
  logic [W-1:0]    mul_b_q, mul_b_d;
  logic [2*W-1:0]  rsp_r_q, rsp_r_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic            mul_start_q, mul_start_d;
  logic            done_q;

  logic            found;
  logic [PW-1:0]   winner;
  logic            done_edge;

  // Edge detect runs in every state so a level-style Done left high from a
  // previous operation cannot complete the next one.
  assign done_edge = MulDone & ~done_q;

  // Winner: first set Req bit searching upward from ptr+1, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= N; i++) begin
      if (!found && Req[(int'(ptr_q) + i) % N]) begin
        found  = 1'b1;
        winner = PW'((int'(ptr_q) + i) % N);
      end
    end
  end

`ifdef SAM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          wd_expired;

  // wd_cnt_q counts completed WAIT cycles; the final allowed cycle is the
  // one where it reads TIMEOUT_CYCLES-1.
  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign RspErr     = rsp_err_q;
`else
  assign RspErr     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_r_d     = rsp_r_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    mul_start_d = 1'b0;
`ifdef SAM_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          mul_a_d     = ReqA[int'(winner)*W +: W];
          mul_b_d     = ReqB[int'(winner)*W +: W];
          owner_d     = winner;
          gnt_d       = ONE_HOT0 << winner;
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SAM_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (done_edge) begin
          rsp_r_d     = MulR;
          rsp_valid_d = ONE_HOT0 << owner_q;
          state_d     = S_RESP;
`ifdef SAM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wd_expired) begin
          rsp_r_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = ONE_HOT0 << owner_q;
          state_d     = S_RESP;
        end else begin
          wd_cnt_d    = wd_cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(N - 1);
      owner_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_r_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SAM_TIMEOUT_EN
      wd_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_r_q     <= rsp_r_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
      done_q      <= MulDone;
`ifdef SAM_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign Gnt      = gnt_q;
  assign RspValid = rsp_valid_q;
  assign RspR     = rsp_r_q;
  assign Busy     = (state_q != S_IDLE);
  assign MulStart = mul_start_q;
  assign MulA     = mul_a_q;
  assign MulB     = mul_b_q;

endmodule
